// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        WDONE
    } state_t;

    localparam int DEFAULT_LINES = 16;

    function automatic int idx_w(input int lines);
        return (lines > 1) ? $clog2(lines) : 1;
    endfunction

    function automatic int tag_w(input int addr_w, input int lines);
        return addr_w - idx_w(lines);
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage: combinational read port, one synchronous write port,
// asynchronous clear of every valid bit.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int LINES  = DEFAULT_LINES,
    parameter int TAG_W  = 12,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [idx_w(LINES)-1:0]  rd_idx_i,
    output logic                     rd_valid_o,
    output logic [TAG_W-1:0]         rd_tag_o,
    output logic [DATA_W-1:0]        rd_data_o,
    input  logic                     wr_en_i,
    input  logic [idx_w(LINES)-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]         wr_tag_i,
    input  logic [DATA_W-1:0]        wr_data_i
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // NOTE: tag/data are deliberately not reset; a line is only ever read
    // through its valid bit, so clearing the payload would just cost flops.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through data cache controller producing the pipeline hit qualifier.
// Optional DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES  = DEFAULT_LINES,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(ADDR_W, LINES);

    state_t            state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [ADDR_W-1:0] lk_addr;
    logic              lk_valid;
    logic [TAG_W-1:0]  lk_tag;
    logic [DATA_W-1:0] lk_data;
    logic              lk_hit;
    logic              ack_ok;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    // IDLE looks up the live request; busy states look up the latched address.
    assign lk_addr = (state_q == IDLE) ? addr : mem_addr_q;
    assign lk_hit  = lk_valid && (lk_tag == lk_addr[ADDR_W-1:IDX_W]);
    assign ack_ok  = mem_req_q && mem_ack;

    assign wr_en   = ack_ok && ((state_q == FILL) || ((state_q == WRITE) && lk_hit));
    assign wr_data = (state_q == FILL) ? mem_rdata : mem_wdata_q;

    dcache_line_array #(
        .LINES  (LINES),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_lines (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (lk_addr[IDX_W-1:0]),
        .rd_valid_o (lk_valid),
        .rd_tag_o   (lk_tag),
        .rd_data_o  (lk_data),
        .wr_en_i    (wr_en),
        .wr_idx_i   (mem_addr_q[IDX_W-1:0]),
        .wr_tag_i   (mem_addr_q[ADDR_W-1:IDX_W]),
        .wr_data_i  (wr_data)
    );

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        hit       = 1'b0;
        read_data = '0;
        unique case (state_q)
            IDLE: begin
                if (mem_write) begin
                    hit = 1'b0;
                end else if (mem_read) begin
                    hit = lk_hit;
                    if (lk_hit) read_data = lk_data;
                end else begin
                    hit = 1'b1;
                end
            end
            WDONE:   hit = 1'b1;
            default: hit = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mem_write) begin
                        mem_addr_q  <= addr;
                        mem_wdata_q <= write_data;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        state_q     <= WRITE;
                    end else if (mem_read && !lk_hit) begin
                        mem_addr_q  <= addr;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        state_q     <= FILL;
                    end
                end
                FILL, WRITE: begin
                    if (ack_ok) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= (state_q == FILL) ? IDLE : WDONE;
                    end
                end
                WDONE:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
    // The re-lookup hit that closes a refill belongs to that miss, not to hit_count.
    logic        refill_q;
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;
    logic        rd_lookup;

    assign rd_lookup = (state_q == IDLE) && mem_read && !mem_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refill_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            refill_q <= (state_q == FILL) && ack_ok;
            if (rd_lookup && lk_hit && !refill_q && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (rd_lookup && !lk_hit && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: transaction-level cache/memory model plus per-cycle checker.
module tb_dcache_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        hit;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int tests = 0;
    int fails = 0;

    dcache_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .hit        (hit),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Main memory contents: untouched words follow a fixed address pattern.
    logic [15:0] bmem [logic [15:0]];

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        if (bmem.exists(a)) return bmem[a];
        if (a == 16'h0005) return 16'hBEEF;
        return a ^ 16'h5A5A;
    endfunction

    // Cache model: which tag (if any) each index currently holds.
    logic        mv [16];
    logic [11:0] mt [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory responder: ack on the LAT-th cycle of a held request.
    logic ack_block = 1'b0;
    int   stray_req = 0;
    int   stray_done;
    initial begin
        int cnt;
        cnt        = 0;
        stray_done = 0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (stray_req != stray_done) begin
                stray_done++;
                mem_ack   = 1'b1;
                mem_rdata = 16'hDEAD;
            end else if (mem_req && !ack_block) begin
                cnt++;
                if (cnt == LAT) begin
                    cnt     = 0;
                    mem_ack = 1'b1;
                    if (mem_we) bmem[mem_addr] = mem_wdata;
                    else        mem_rdata = mem_val(mem_addr);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Per-cycle checker: write-through means any read hit must return memory's value.
    logic [15:0] last_waddr = '0;
    logic [15:0] last_wdata = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (!mem_read && !mem_write) check("idle_hit", hit, 1'b1);
            if (hit && mem_read && !mem_write) check("hit_data", read_data, mem_val(addr));
            if (!hit) check("miss_data_zero", read_data, 16'h0);
            if (mem_req) begin
                check("mem_addr", mem_addr, addr);
                check("mem_we", mem_we, mem_write);
                if (mem_we) begin
                    check("mem_wdata", mem_wdata, write_data);
                    last_waddr <= mem_addr;
                    last_wdata <= mem_wdata;
                end
            end
        end
    end

    task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d,
                          output int stall, output logic [15:0] rd);
        logic exp_hit;
        int   exp_stall;
        exp_hit   = !we && mv[a[3:0]] && (mt[a[3:0]] == a[15:4]);
        exp_stall = exp_hit ? 0 : LAT + 1;
        @(posedge clk);
        #1;
        mem_write  = we;
        mem_read   = !we;
        addr       = a;
        write_data = d;
        stall      = 0;
        @(negedge clk);
        while (hit !== 1'b1) begin
            stall++;
            if (stall > 30) break;
            @(negedge clk);
        end
        rd = read_data;
        check($sformatf("stall_%s_%h", we ? "wr" : "rd", a), stall, exp_stall);
        if (!we) begin
            mv[a[3:0]] = 1'b1;
            mt[a[3:0]] = a[15:4];
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, fails so far %0d", fails);
        $fatal(1);
    end

    initial begin
        int          st;
        logic [15:0] rd;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr       = '0;
        write_data = '0;
        rst_n      = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mv[i] = 1'b0;
            mt[i] = '0;
        end
        @(negedge clk);
        check("rst_hit", hit, 1'b1);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_mem_wdata", mem_wdata, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss, then zero-stall hit
        access(1'b0, 16'h0005, 16'h0, st, rd);
        check("first_miss_stall", st, 4);
        check("first_miss_data", rd, 16'hBEEF);
        access(1'b0, 16'h0005, 16'h0, st, rd);
        check("repeat_hit_stall", st, 0);
        check("repeat_hit_data", rd, 16'hBEEF);

        // Conflict on index 5
        access(1'b0, 16'h0015, 16'h0, st, rd);
        check("conflict_data", rd, 16'h5A4F);
        access(1'b0, 16'h0005, 16'h0, st, rd);
        check("evicted_stall", st, 4);

        // Store to cached line updates it
        access(1'b1, 16'h0005, 16'h1234, st, rd);
        check("store_stall", st, 4);
        check("store_waddr", last_waddr, 16'h0005);
        check("store_wdata", last_wdata, 16'h1234);
        access(1'b0, 16'h0005, 16'h0, st, rd);
        check("store_then_hit_stall", st, 0);
        check("store_then_hit_data", rd, 16'h1234);

        // Store to uncached line does not allocate
        access(1'b1, 16'h0030, 16'hCAFE, st, rd);
        access(1'b0, 16'h0030, 16'h0, st, rd);
        check("no_alloc_stall", st, 4);
        check("no_alloc_data", rd, 16'hCAFE);

        // Top index and index 0
        access(1'b0, 16'h00FF, 16'h0, st, rd);
        access(1'b1, 16'h00FF, 16'h0F0F, st, rd);
        access(1'b0, 16'h00FF, 16'h0, st, rd);
        check("top_idx_update", rd, 16'h0F0F);
        access(1'b0, 16'h0000, 16'h0, st, rd);
        access(1'b0, 16'hFFF0, 16'h0, st, rd);

        // Reset during FILL, then a stray ack
        ack_block = 1'b1;
        @(posedge clk);
        #1;
        mem_read = 1'b1;
        addr     = 16'h0040;
        @(negedge clk);
        check("fill_cycle0_hit", hit, 1'b0);
        @(negedge clk);
        check("fill_req_up", mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_drops_req", mem_req, 1'b0);
        check("rst_drops_we", mem_we, 1'b0);
        mem_read = 1'b0;
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        ack_block = 1'b0;
        stray_req++;
        repeat (3) @(negedge clk);
        check("stray_ack_req", mem_req, 1'b0);
        check("stray_ack_hit", hit, 1'b1);
        access(1'b0, 16'h0040, 16'h0, st, rd);
        check("after_rst_0040_stall", st, 4);
        check("after_rst_0040_data", rd, 16'h5A1A);
        access(1'b0, 16'h0005, 16'h0, st, rd);
        access(1'b0, 16'h00FF, 16'h0, st, rd);
        access(1'b0, 16'h0030, 16'h0, st, rd);

`ifdef DCACHE_STATS_EN
        do_reset();
        @(negedge clk);
        check("stats_rst_hit", hit_count, 16'd0);
        check("stats_rst_miss", miss_count, 16'd0);
        access(1'b0, 16'h0100, 16'h0, st, rd);
        access(1'b0, 16'h0101, 16'h0, st, rd);
        access(1'b0, 16'h0102, 16'h0, st, rd);
        access(1'b0, 16'h0100, 16'h0, st, rd);
        access(1'b0, 16'h0101, 16'h0, st, rd);
        access(1'b0, 16'h0102, 16'h0, st, rd);
        access(1'b0, 16'h0100, 16'h0, st, rd);
        access(1'b0, 16'h0101, 16'h0, st, rd);
        @(negedge clk);
        check("stats_miss", miss_count, 16'd3);
        check("stats_hit", hit_count, 16'd5);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
